// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin arbiter that lets four requesters share one byte-wide UART
// transmitter. A request is granted only while the arbiter is idle and the
// UART reports txrdy. The granted byte is then strobed out on tx_vld, and the
// arbiter waits for the UART's txrdy handshake (high -> low -> high) before
// it grants again. If txrdy never falls after a strobe, the byte is dropped,
// tmo_err pulses and the arbiter goes back to idle.
//
// Optional feature (compile-time macro UART_TX_TAG_EN):
//   Each grant first sends a tag byte TAG_BASE | src and then sends the
//   data byte. Each byte gets its own txrdy handshake. A timeout on the tag
//   byte abandons the data byte.
//
// Parameters:
//   TAG_BASE  base value of the tag byte (low two bits carry the source)
//   BUSY_TMO  WAIT_LO cycles allowed for txrdy to fall, 2..15
//
// Ports:
//   clk                  rising-edge clock
//   rst                  asynchronous active-high reset
//   req[3:0]             per-requester send request, held until ack
//   req_data0..3[7:0]    requester bytes, stable while req is high
//   ack[3:0]             one-cycle pulse: requester's byte captured
//   tx_vld               one-cycle strobe to the UART transmitter
//   tx_data[7:0]         byte presented with tx_vld (held otherwise)
//   txrdy                UART idle (low while a frame is in flight)
//   busy                 high whenever the FSM is not in IDLE
//   last_src[1:0]        most recently granted requester
//   tmo_err              one-cycle pulse on txrdy timeout
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter logic [7:0]  TAG_BASE = 8'hA0,
  parameter int unsigned BUSY_TMO = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  input  logic [7:0] req_data2,
  input  logic [7:0] req_data3,
  output logic [3:0] ack,
  output logic       tx_vld,
  output logic [7:0] tx_data,
  input  logic       txrdy,
  output logic       busy,
  output logic [1:0] last_src,
  output logic       tmo_err
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] WAIT_LO   = 3'd2;
  localparam logic [2:0] WAIT_HI   = 3'd3;
`ifdef UART_TX_TAG_EN
  localparam logic [2:0] TAG_ISSUE = 3'd4;
`endif

  // The counter starts at 0 on the first WAIT_LO cycle, so the last allowed
  // cycle is the one where it reads BUSY_TMO-1.
  localparam logic [3:0] TMO_LAST = 4'(BUSY_TMO - 1);

  logic [2:0] state;
  logic [3:0] wait_cnt;
  logic       grant_vld;
  logic [1:0] grant_idx;
  logic [1:0] cand;
  logic [7:0] grant_data;

`ifdef UART_TX_TAG_EN
  // Data byte parked here while the tag byte is on the wire; tag_phase says
  // the current handshake belongs to the tag so WAIT_HI continues to ISSUE.
  logic [7:0] byte_q;
  logic       tag_phase;
`else
  // Without tagging only the data byte goes out, and tx_data itself is the
  // latched byte register. The tag base is kept referenced here.
  logic [7:0] unused_tag_base;
  assign unused_tag_base = TAG_BASE;
`endif

  assign busy = (state != IDLE);

  // Round-robin search starting one past the last winner; 2-bit wrap makes
  // last_src=3 start the search at 0.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last_src;
    cand      = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_src + 2'(i);
      if (!grant_vld && req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    case (grant_idx)
      2'd0:    grant_data = req_data0;
      2'd1:    grant_data = req_data1;
      2'd2:    grant_data = req_data2;
      default: grant_data = req_data3;
    endcase
  end

  // ack, tx_vld and tmo_err default low every cycle so they can only ever be
  // single-cycle pulses. tx_vld is set on the edge that enters ISSUE or
  // TAG_ISSUE, so it is high exactly while the FSM sits in that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      last_src  <= 2'd3;
      ack       <= 4'd0;
      tx_vld    <= 1'b0;
      tx_data   <= 8'h00;
      tmo_err   <= 1'b0;
`ifdef UART_TX_TAG_EN
      byte_q    <= 8'h00;
      tag_phase <= 1'b0;
`endif
    end else begin
      ack     <= 4'd0;
      tx_vld  <= 1'b0;
      tmo_err <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_vld && txrdy) begin
            last_src <= grant_idx;
            ack      <= 4'b0001 << grant_idx;
            tx_vld   <= 1'b1;
`ifdef UART_TX_TAG_EN
            byte_q    <= grant_data;
            tx_data   <= TAG_BASE | {6'b0, grant_idx};
            tag_phase <= 1'b1;
            state     <= TAG_ISSUE;
`else
            tx_data  <= grant_data;
            state    <= ISSUE;
`endif
          end
        end
`ifdef UART_TX_TAG_EN
        TAG_ISSUE: begin
          wait_cnt <= 4'd0;
          state    <= WAIT_LO;
        end
`endif
        ISSUE: begin
          wait_cnt <= 4'd0;
          state    <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!txrdy) begin
            state <= WAIT_HI;
          end else if (wait_cnt == TMO_LAST) begin
            // Byte is abandoned; a tag timeout also abandons the data byte.
            tmo_err <= 1'b1;
            state   <= IDLE;
`ifdef UART_TX_TAG_EN
            tag_phase <= 1'b0;
`endif
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        WAIT_HI: begin
          if (txrdy) begin
`ifdef UART_TX_TAG_EN
            if (tag_phase) begin
              tag_phase <= 1'b0;
              tx_vld    <= 1'b1;
              tx_data   <= byte_q;
              state     <= ISSUE;
            end else begin
              state <= IDLE;
            end
`else
            state <= IDLE;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter: reset values, a table of single
// grants walking the round-robin pointer, hand-written corner sequences
// (txrdy low in idle, timeout, reset mid-frame, held 4-way request), and a
// randomized run scored against a transaction-level model (round-robin
// winner, byte queue, UART handshake responder).
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam logic [7:0] TAG_BASE = 8'hA0;
  localparam int         BUSY_TMO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [7:0] req_data0, req_data1, req_data2, req_data3;
  logic [3:0] ack;
  logic       tx_vld;
  logic [7:0] tx_data;
  logic       txrdy;
  logic       busy;
  logic [1:0] last_src;
  logic       tmo_err;

  int checks_total  = 0;
  int checks_passed = 0;

  typedef struct {
    logic [3:0] req;
    logic [7:0] base;
    logic [3:0] exp_ack;
    logic [7:0] exp_data;
    logic [1:0] exp_last;
  } vec_t;

  vec_t vecs[10];

  uart_tx_arbiter #(
    .TAG_BASE (TAG_BASE),
    .BUSY_TMO (BUSY_TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_data2 (req_data2),
    .req_data3 (req_data3),
    .ack       (ack),
    .tx_vld    (tx_vld),
    .tx_data   (tx_data),
    .txrdy     (txrdy),
    .busy      (busy),
    .last_src  (last_src),
    .tmo_err   (tmo_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setData(input int idx, input logic [7:0] val);
    case (idx)
      0:       req_data0 = val;
      1:       req_data1 = val;
      2:       req_data2 = val;
      default: req_data3 = val;
    endcase
  endtask

  task automatic doReset();
    rst   = 1'b1;
    req   = 4'd0;
    txrdy = 1'b1;
    for (int i = 0; i < 4; i++) setData(i, 8'h00);
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // UART frame: txrdy low for lo cycles, then back high.
  task automatic uartFrame(input string name, input int lo);
    logic [3:0] stray;
    stray = 4'd0;
    txrdy = 1'b0;
    for (int i = 0; i < lo; i++) begin
      tick();
      stray |= ack;
    end
    txrdy = 1'b1;
    checkOutput({name, " no stray ack"}, 32'(stray), 32'd0);
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    checkOutput({name, " returns idle"}, 32'(busy), 32'd0);
  endtask

  task automatic waitTxVld(input string name);
    int n;
    n = 0;
    while (!tx_vld && n < 200) begin
      tick();
      n++;
    end
    checkOutput({name, " tx_vld seen"}, 32'(tx_vld), 32'd1);
  endtask

  task automatic waitAck(input string name);
    int n;
    n = 0;
    tick();
    while (ack == 4'd0 && n < 200) begin
      tick();
      n++;
    end
    checkOutput({name, " ack seen"}, 32'(ack != 4'd0), 32'd1);
  endtask

  // Called at the sample of the first tx_vld after a grant.
  task automatic completeTransfer(input string name, input logic [1:0] src,
                                  input logic [7:0] data, input int lo);
`ifdef UART_TX_TAG_EN
    logic [7:0] tag;
    tag = TAG_BASE | {6'b0, src};
    checkOutput({name, " tag byte"}, 32'(tx_data), 32'(tag));
    uartFrame(name, lo);
    waitTxVld(name);
`else
    checkOutput({name, " src"}, 32'(last_src), 32'(src));
`endif
    checkOutput({name, " data byte"}, 32'(tx_data), 32'(data));
    uartFrame(name, lo);
    waitIdle(name);
  endtask

  task automatic applyStimulus(input string name, input vec_t v);
    for (int i = 0; i < 4; i++) setData(i, v.base + 8'(i));
    req   = v.req;
    txrdy = 1'b1;
    tick();
    checkOutput({name, " ack"}, 32'(ack), 32'(v.exp_ack));
    checkOutput({name, " last_src"}, 32'(last_src), 32'(v.exp_last));
    checkOutput({name, " tx_vld"}, 32'(tx_vld), 32'd1);
    req = 4'd0;
    completeTransfer(name, v.exp_last, v.exp_data, 3);
  endtask

  // Random-phase model state
  logic [7:0] exp_q[$];
  logic [7:0] pdata[4];
  int         age[4];
  int         model_last, w, idx, grants, pre_cnt, low_cnt;
  logic       uart_active, prev_vld, starved, tmo_seen, seen_txrdy;
  logic [3:0] seen_req, stray4;
  logic [7:0] last_tx, exp_byte;
  logic       acc;

  initial begin
    vecs[0] = '{4'b0001, 8'h55, 4'b0001, 8'h55, 2'd0};
    vecs[1] = '{4'b1111, 8'h20, 4'b0010, 8'h21, 2'd1};
    vecs[2] = '{4'b1001, 8'h30, 4'b1000, 8'h33, 2'd3};
    vecs[3] = '{4'b0111, 8'h40, 4'b0001, 8'h40, 2'd0};
    vecs[4] = '{4'b0100, 8'h50, 4'b0100, 8'h52, 2'd2};
    vecs[5] = '{4'b0100, 8'h60, 4'b0100, 8'h62, 2'd2};
    vecs[6] = '{4'b0011, 8'h70, 4'b0001, 8'h70, 2'd0};
    vecs[7] = '{4'b1000, 8'h8D, 4'b1000, 8'h90, 2'd3};
    vecs[8] = '{4'b0010, 8'hFE, 4'b0010, 8'hFF, 2'd1};
    vecs[9] = '{4'b1110, 8'hC0, 4'b0100, 8'hC2, 2'd2};

    // Reset values while rst is held
    rst = 1'b1; req = 4'd0; txrdy = 1'b1;
    for (int i = 0; i < 4; i++) setData(i, 8'h00);
    tick();
    tick();
    checkOutput("reset ack", 32'(ack), 32'd0);
    checkOutput("reset tx_vld", 32'(tx_vld), 32'd0);
    checkOutput("reset tx_data", 32'(tx_data), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset last_src", 32'(last_src), 32'd3);
    checkOutput("reset tmo_err", 32'(tmo_err), 32'd0);
    rst = 1'b0;
    tick();

    // Table of single grants walking the round-robin pointer
    for (int k = 0; k < 10; k++) applyStimulus($sformatf("tbl%0d", k), vecs[k]);

    // txrdy low in idle holds off the grant
    $display("[TB] txrdy low in idle");
    txrdy = 1'b0; req = 4'b0100; setData(2, 8'hA7);
    stray4 = 4'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      stray4 |= ack;
    end
    checkOutput("txrdy low no ack", 32'(stray4), 32'd0);
    checkOutput("txrdy low idle", 32'(busy), 32'd0);
    txrdy = 1'b1;
    tick();
    checkOutput("txrdy high ack", 32'(ack), 32'b0100);
    req = 4'd0;
    completeTransfer("txrdy low", 2'd2, 8'hA7, 3);

    // Timeout: txrdy stuck high after the strobe
    $display("[TB] busy timeout");
    req = 4'b0001; setData(0, 8'h5A);
    waitAck("tmo");
    checkOutput("tmo ack", 32'(ack), 32'b0001);
    req = 4'd0;
    acc = 1'b0;
    for (int i = 0; i < BUSY_TMO; i++) begin
      tick();
      acc |= tmo_err;
    end
    checkOutput("tmo not early", 32'(acc), 32'd0);
    tick();
    checkOutput("tmo pulse", 32'(tmo_err), 32'd1);
    checkOutput("tmo busy cleared", 32'(busy), 32'd0);
    acc = 1'b0;
    tick();
    checkOutput("tmo single pulse", 32'(tmo_err), 32'd0);
    for (int i = 0; i < 8; i++) begin
      acc |= tx_vld;
      tick();
    end
    checkOutput("tmo byte dropped", 32'(acc), 32'd0);
    req = 4'b0010; setData(1, 8'h66);
    waitAck("after tmo");
    checkOutput("after tmo ack", 32'(ack), 32'b0010);
    req = 4'd0;
    completeTransfer("after tmo", 2'd1, 8'h66, 3);

    // Reset asserted while waiting for txrdy to return
    $display("[TB] reset during WAIT_HI");
    req = 4'b0100; setData(2, 8'h99);
    waitAck("rst mid");
    req = 4'd0;
    txrdy = 1'b0;
    tick();
    tick();
    checkOutput("rst mid busy before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst mid ack", 32'(ack), 32'd0);
    checkOutput("rst mid tx_vld", 32'(tx_vld), 32'd0);
    checkOutput("rst mid tx_data", 32'(tx_data), 32'd0);
    checkOutput("rst mid busy", 32'(busy), 32'd0);
    checkOutput("rst mid last_src", 32'(last_src), 32'd3);
    checkOutput("rst mid tmo_err", 32'(tmo_err), 32'd0);
    txrdy = 1'b1;
    tick();
    rst = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      acc |= tx_vld | (ack != 4'd0);
    end
    checkOutput("rst mid no spurious", 32'(acc), 32'd0);

    // All four requesting, slow UART: order 0,1,2,3,0
    $display("[TB] held 4-way request");
    doReset();
    for (int i = 0; i < 4; i++) setData(i, 8'hB0 + 8'(i));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      waitAck($sformatf("rr%0d", k));
      checkOutput($sformatf("rr%0d ack", k), 32'(ack), 32'(4'b0001 << (k % 4)));
      checkOutput($sformatf("rr%0d last_src", k), 32'(last_src), 32'(k % 4));
      completeTransfer($sformatf("rr%0d", k), 2'(k % 4), 8'hB0 + 8'(k % 4), 20);
    end
    req = 4'd0;

    // Randomized run against the transaction-level model
    $display("[TB] random run");
    doReset();
    model_last = 3; grants = 0; uart_active = 1'b0; prev_vld = 1'b0;
    starved = 1'b0; tmo_seen = 1'b0; last_tx = 8'h00; pre_cnt = 0; low_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      age[i] = 0;
      pdata[i] = 8'h00;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      seen_req   = req;
      seen_txrdy = txrdy;
      tick();
      tmo_seen |= tmo_err;

      if (ack != 4'd0) begin
        w = -1;
        for (int k = 1; k <= 4; k++) begin
          idx = (model_last + k) % 4;
          if (w < 0 && seen_req[idx]) w = idx;
        end
        checkOutput("rnd ack", 32'(ack), (w < 0) ? 32'd0 : 32'(4'b0001 << w));
        if (w >= 0) begin
          checkOutput("rnd txrdy at grant", 32'(seen_txrdy), 32'd1);
          model_last = w;
          checkOutput("rnd last_src", 32'(last_src), 32'(w));
          grants++;
`ifdef UART_TX_TAG_EN
          exp_q.push_back(TAG_BASE | 8'(w));
`endif
          exp_q.push_back(pdata[w]);
          req[w] = 1'b0;
          age[w] = 0;
        end
      end

      if (tx_vld) begin
        checkOutput("rnd tx_vld spacing", 32'(prev_vld), 32'd0);
        if (exp_q.size() == 0) begin
          checkOutput("rnd tx_vld pending", 32'(tx_vld), 32'd0);
        end else begin
          exp_byte = exp_q.pop_front();
          checkOutput("rnd tx_data", 32'(tx_data), 32'(exp_byte));
          last_tx = exp_byte;
        end
        uart_active = 1'b1;
        pre_cnt = $urandom_range(0, 2);
        low_cnt = $urandom_range(3, 8);
      end else begin
        checkOutput("rnd tx_data hold", 32'(tx_data), 32'(last_tx));
      end
      prev_vld = tx_vld;

      if (uart_active) begin
        if (pre_cnt > 0) begin
          pre_cnt--;
          txrdy = 1'b1;
        end else if (low_cnt > 0) begin
          low_cnt--;
          txrdy = 1'b0;
        end else begin
          txrdy = 1'b1;
          uart_active = 1'b0;
        end
      end else if (cyc < 1850) begin
        txrdy = ($urandom_range(0, 7) != 0);
      end else begin
        txrdy = 1'b1;
      end

      if (cyc < 1850) begin
        for (int i = 0; i < 4; i++) begin
          if (req[i] && ack == 4'd0 && $urandom_range(0, 31) == 0) begin
            req[i] = 1'b0;
          end else if (!req[i] && $urandom_range(0, 3) == 0) begin
            pdata[i] = 8'($urandom);
            setData(i, pdata[i]);
            req[i] = 1'b1;
          end
        end
      end else begin
        req = 4'd0;
      end

      for (int i = 0; i < 4; i++) begin
        if (req[i]) age[i]++;
        else age[i] = 0;
        if (age[i] > 400) starved = 1'b1;
      end
    end
    checkOutput("rnd queue drained", 32'(exp_q.size()), 32'd0);
    checkOutput("rnd no starvation", 32'(starved), 32'd0);
    checkOutput("rnd no timeout", 32'(tmo_seen), 32'd0);
    checkOutput("rnd enough grants", 32'(grants >= 20), 32'd1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
